ft_recovery_unit: RTL

// Executes the state restoration that the ft_control FSM requests. On a recover request it

---
 rtl/ft_recovery_unit.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/ft_recovery_unit.sv
// rtl/ft_recovery_unit.sv - register-file copy and checkpoint PC reload after a fault recovery request
// Reads x1..x(NUM_REGS-1) from the healthy core, writes them one cycle later, then strobes the PC.
module ft_recovery_unit #(
    parameter int unsigned       NUM_REGS = 32,
    parameter int unsigned       ADDR_W   = 5,
    parameter int unsigned       DATA_W   = 32,
    parameter logic [DATA_W-1:0] RESET_PC = 32'h0000_0080
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              recover_i,
    input  logic              recovering_i,
    input  logic              load_pc_i,
    input  logic [DATA_W-1:0] pc_i,
    output logic [ADDR_W-1:0] rf_raddr_o,
    input  logic [DATA_W-1:0] rf_rdata_i,
    output logic              rf_we_o,
    output logic [ADDR_W-1:0] rf_waddr_o,
    output logic [DATA_W-1:0] rf_wdata_o,
    output logic [DATA_W-1:0] pc_o,
    output logic              pc_valid_o,
    output logic              recovery_done_o,
    output logic              busy_o,
    output logic [7:0]        recovery_cnt_o
);

    typedef enum logic [2:0] {
        IDLE,
        COPY,
        DRAIN,
        LOAD_PC,
        DONE
    } state_t;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_REGS - 1);

    state_t            state_q;
    logic              recover_q;
    logic [DATA_W-1:0] pc_ckpt_q;
    logic [ADDR_W-1:0] raddr_q;
    logic [ADDR_W-1:0] waddr_q;
    logic              we_q;
    logic [DATA_W-1:0] pc_q;
    logic              pc_valid_q;
    logic              done_q;
    logic [7:0]        cnt_q;
    logic              start;

    assign start = recover_i & ~recover_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= IDLE;
            recover_q  <= 1'b0;
            pc_ckpt_q  <= RESET_PC;
            raddr_q    <= '0;
            waddr_q    <= '0;
            we_q       <= 1'b0;
            pc_q       <= '0;
            pc_valid_q <= 1'b0;
            done_q     <= 1'b0;
            cnt_q      <= 8'd0;
        end else begin
            recover_q <= recover_i;
            case (state_q)
                IDLE: begin
                    we_q       <= 1'b0;
                    pc_valid_q <= 1'b0;
                    done_q     <= 1'b0;
                    if (load_pc_i) begin
                        pc_ckpt_q <= pc_i;
                    end
                    if (start) begin
                        state_q <= COPY;
                        raddr_q <= ADDR_W'(1);
                    end
                end
                COPY: begin
                    if (!recovering_i) begin
                        state_q <= IDLE;
                        raddr_q <= '0;
                        we_q    <= 1'b0;
                    end else begin
                        // The read issued this cycle becomes next cycle's write.
                        we_q    <= 1'b1;
                        waddr_q <= raddr_q;
                        if (raddr_q == LAST_ADDR) begin
                            state_q <= DRAIN;
                            raddr_q <= '0;
                        end else begin
                            raddr_q <= raddr_q + ADDR_W'(1);
                        end
                    end
                end
                DRAIN: begin
                    we_q    <= 1'b0;
                    waddr_q <= '0;
                    if (!recovering_i) begin
                        state_q <= IDLE;
                    end else begin
                        state_q    <= LOAD_PC;
                        pc_q       <= pc_ckpt_q;
                        pc_valid_q <= 1'b1;
                    end
                end
                LOAD_PC: begin
                    pc_q       <= '0;
                    pc_valid_q <= 1'b0;
                    if (!recovering_i) begin
                        state_q <= IDLE;
                    end else begin
                        state_q <= DONE;
                        done_q  <= 1'b1;
                    end
                end
                DONE: begin
                    if (!recovering_i) begin
                        state_q <= IDLE;
                        done_q  <= 1'b0;
                        if (cnt_q != 8'hFF) begin
                            cnt_q <= cnt_q + 8'd1;
                        end
                    end
                end
                default: begin
                    state_q    <= IDLE;
                    raddr_q    <= '0;
                    we_q       <= 1'b0;
                    pc_valid_q <= 1'b0;
                    done_q     <= 1'b0;
                end
            endcase
        end
    end

    assign rf_raddr_o      = raddr_q;
    assign rf_we_o         = we_q;
    assign rf_waddr_o      = waddr_q;
    assign rf_wdata_o      = we_q ? rf_rdata_i : '0;
    assign pc_o            = pc_q;
    assign pc_valid_o      = pc_valid_q;
    assign recovery_done_o = done_q;
    assign busy_o          = (state_q != IDLE);
    assign recovery_cnt_o  = cnt_q;

endmodule
